// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the four-way round-robin channel arbiter.
// Pure definitions: no logic, no latency.
// Backpressure is handled by the arbiter top, not here.
package mux_arb_defs;
    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/channel bundle between four serial sources and the shared 1-bit channel.
// Wires only: no latency.
// Backpressure: out_ready flows back to the granted source as in_ready.
interface mux_rr_arbiter_if;
    import mux_arb_defs::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] din;
    logic [NREQ-1:0] dlast;
    logic [NREQ-1:0] in_ready;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] sel;
    logic            out_valid;
    logic            out_data;
    logic            out_last;
    logic            out_ready;

    modport master (
        input  req, din, dlast, out_ready,
        output in_ready, gnt, sel, out_valid, out_data, out_last
    );

    modport slave (
        output req, din, dlast, out_ready,
        input  in_ready, gnt, sel, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating first-one finder: scans req upward from ptr, wrapping 3 to 0.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick4
    import mux_arb_defs::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [SELW-1:0] idx
);
    always_comb begin
        logic [SELW-1:0] j;
        logic            found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = ptr + SELW'(i);
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering four serial requesters onto one 1-bit channel.
// Latency: grant registered one cycle after req; beats pass combinationally while granted.
// Backpressure: out_ready gates in_ready of the granted source; release costs one idle cycle.
module mux_rr_arbiter
    import mux_arb_defs::*;
#(
    parameter int MAX_BEATS = 8,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.master  bus
);
    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] pick;
    logic [SELW-1:0] pick_idx;
    logic            busy;
    logic            vld;
    logic            last;
    logic            xfer;
    logic [CW-1:0]   cnt_inc;

    rr_pick4 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // rst_n gates the valids so a mid-packet reset never reports a transfer
    assign busy    = (state_q == BUSY);
    assign vld     = busy & rst_n & bus.req[sel_q];
    assign last    = busy & bus.dlast[sel_q];
    assign xfer    = vld & bus.out_ready;
    assign cnt_inc = cnt_q + CW'(1);

    assign bus.out_valid = vld;
    assign bus.out_data  = busy & bus.din[sel_q];
    assign bus.out_last  = last;
    assign bus.in_ready  = (busy && rst_n) ? (gnt_q & {NREQ{bus.out_ready}}) : '0;
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                end
                // sel is left alone on release so the mux select never glitches
                if ((xfer && (last || cnt_inc == CW'(MAX_BEATS))) || !bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, forced release, backpressure, abandon, mid-packet reset.
module tb_mux_rr_arbiter;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    mux_rr_arbiter_if bus();

    mux_rr_arbiter #(.MAX_BEATS(8), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_d [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        errs          = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.din       = 4'b0000;
        bus.dlast     = 4'b0000;
        bus.out_ready = 1'b1;

        // reset held three edges with all requesters active
        repeat (3) step();
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_vld", 32'(bus.out_valid), 32'h0);
        chk("rst_rdy", 32'(bus.in_ready), 32'h0);
        rst_n   = 1'b1;
        bus.din = 4'b1010;
        step();

        // rotation with 2-beat packets, one idle bubble between grants
        for (int k = 0; k < 5; k++) begin
            bus.dlast = 4'b0000;
            #1;
            chk("rot_gnt", 32'(bus.gnt), 32'(exp_g[k]));
            chk("rot_sel", 32'(bus.sel), 32'(exp_i[k]));
            chk("rot_vld", 32'(bus.out_valid), 32'h1);
            chk("rot_rdy", 32'(bus.in_ready), 32'(exp_g[k]));
            chk("rot_dat", 32'(bus.out_data), 32'(exp_d[k]));
            step();
            bus.dlast = 4'b1111;
            #1;
            chk("rot_gnt2", 32'(bus.gnt), 32'(exp_g[k]));
            chk("rot_last", 32'(bus.out_last), 32'h1);
            step();
            if (k == 4) bus.req = 4'b0000;
            #1;
            chk("rot_idle", 32'(bus.gnt), 32'h0);
            chk("rot_ivld", 32'(bus.out_valid), 32'h0);
            chk("rot_hold", 32'(bus.sel), 32'(exp_i[k]));
            step();
        end

        // forced release after 8 beats from requester 2
        bus.req   = 4'b0100;
        bus.dlast = 4'b0000;
        bus.din   = 4'b0100;
        step();
        #1;
        chk("frc_sel", 32'(bus.sel), 32'h2);
        chk("frc_dat", 32'(bus.out_data), 32'h1);
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("frc_hold", 32'(bus.gnt), 32'h4);
            chk("frc_cnt", 32'(dut.cnt_q), 32'(b));
            step();
        end
        #1;
        chk("frc_rel", 32'(bus.gnt), 32'h0);
        chk("frc_ptr", 32'(dut.ptr_q), 32'h3);
        chk("frc_ivld", 32'(bus.out_valid), 32'h0);
        step();
        #1;
        chk("frc_regnt", 32'(bus.gnt), 32'h4);
        chk("frc_cnt0", 32'(dut.cnt_q), 32'h0);
        bus.req   = 4'b0101;
        bus.dlast = 4'b0100;
        #1;
        chk("frc_last", 32'(bus.out_last), 32'h1);
        step();
        #1;
        chk("frc_rel2", 32'(bus.gnt), 32'h0);
        step();
        #1;
        chk("frc_wrap", 32'(bus.gnt), 32'h1);
        bus.dlast = 4'b0101;
        step();
        bus.req = 4'b0000;
        step();

        // backpressure on requester 1: out_ready 1,0,0,1
        bus.req       = 4'b0010;
        bus.dlast     = 4'b0000;
        bus.out_ready = 1'b1;
        step();
        #1;
        chk("bp_gnt", 32'(bus.gnt), 32'h2);
        chk("bp_rdy1", 32'(bus.in_ready), 32'h2);
        chk("bp_cnt0", 32'(dut.cnt_q), 32'h0);
        step();
        bus.out_ready = 1'b0;
        bus.dlast     = 4'b0010;
        #1;
        chk("bp_rdy2", 32'(bus.in_ready), 32'h0);
        chk("bp_vld2", 32'(bus.out_valid), 32'h1);
        chk("bp_cnt1", 32'(dut.cnt_q), 32'h1);
        step();
        #1;
        chk("bp_hold", 32'(bus.gnt), 32'h2);
        chk("bp_cnt1b", 32'(dut.cnt_q), 32'h1);
        chk("bp_rdy3", 32'(bus.in_ready), 32'h0);
        step();
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy4", 32'(bus.in_ready), 32'h2);
        chk("bp_last", 32'(bus.out_last), 32'h1);
        step();
        #1;
        chk("bp_rel", 32'(bus.gnt), 32'h0);
        chk("bp_ptr", 32'(dut.ptr_q), 32'h2);
        bus.req = 4'b0000;
        step();

        // requester 3 abandons mid-packet, then 2 is granted skipping 0 and 1
        bus.req   = 4'b1000;
        bus.dlast = 4'b0000;
        step();
        #1;
        chk("ab_gnt", 32'(bus.gnt), 32'h8);
        step();
        bus.req = 4'b0100;
        #1;
        chk("ab_vld", 32'(bus.out_valid), 32'h0);
        chk("ab_rdy", 32'(bus.in_ready), 32'h8);
        step();
        #1;
        chk("ab_rel", 32'(bus.gnt), 32'h0);
        chk("ab_ptr", 32'(dut.ptr_q), 32'h0);
        step();
        #1;
        chk("ab_skip", 32'(bus.gnt), 32'h4);

        // reset during beat 3 of requester 1
        bus.dlast = 4'b0100;
        step();
        bus.req   = 4'b0010;
        bus.dlast = 4'b0000;
        step();
        #1;
        chk("rm_gnt", 32'(bus.gnt), 32'h2);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rm_cnt2", 32'(dut.cnt_q), 32'h2);
        chk("rm_vld", 32'(bus.out_valid), 32'h0);
        chk("rm_rdy", 32'(bus.in_ready), 32'h0);
        step();
        #1;
        chk("rm_gnt0", 32'(bus.gnt), 32'h0);
        chk("rm_ptr", 32'(dut.ptr_q), 32'h0);
        chk("rm_cnt", 32'(dut.cnt_q), 32'h0);
        chk("rm_sel", 32'(bus.sel), 32'h0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        step();
        #1;
        chk("rm_idle", 32'(bus.gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
